data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words of RAM (power of two, 4..4096).
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_0000, meaning byte base address of the I/O register window.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port memory_write_en  input  1  CPU write strobe for the current cycle.
REQ-006 SHALL have port memory_address  input  32  CPU byte address.
REQ-007 SHALL have port memory_write_value  input  32  CPU write data.
REQ-008 SHALL have port memory_read_value  output  32  read data for memory_address, combinational.
REQ-009 SHALL have port io_in  input  32  external input word, readable through MMIO.
REQ-010 SHALL have port io_out  output  32  registered external output word.
REQ-011 SHALL have port busy  output  1  high while RAM clear sweep runs.
REQ-012 SHALL have port fault  output  1  sticky access-error flag.

Function
REQ-013 SHALL implement a two-state FSM: INIT (clear sweep) and READY.
REQ-014 In INIT, it SHALL write zero to one word per cycle, index 0..DEPTH-1, then enter READY on the cycle after index DEPTH-1 is cleared; sweep length is exactly DEPTH cycles.
REQ-015 busy SHALL be 1 in INIT and 0 in READY; in INIT, CPU writes are ignored (no fault) and memory_read_value is 0.
REQ-016 RAM decode: word index = memory_address[31:2]; in range iff memory_address < DEPTH*4.
REQ-017 Reads SHALL be combinational, zero-latency; a read of an address written in the same cycle returns the pre-edge value.
REQ-018 Writes SHALL take effect at the rising edge where memory_write_en=1; new value visible the following cycle.
REQ-019 Out-of-range or misaligned (memory_address[1:0]!=0) reads SHALL return 0 and SHALL NOT set fault.
REQ-020 A write (in READY) that is misaligned or unmapped SHALL be discarded and SHALL set fault at that edge.
REQ-021 fault SHALL remain 1 until reset.

Reset
REQ-022 While reset_n=0 at a rising edge: FSM -> INIT, sweep index -> 0, io_out -> 0, cycle counter -> 0, fault -> 0, busy -> 1.
REQ-023 Reset asserted mid-sweep SHALL restart the sweep at index 0.
REQ-024 Reset asserted in READY SHALL re-clear all RAM via a full sweep.
REQ-025 Outputs SHALL NOT change asynchronously with reset_n.

Configuration
REQ-026 Macro DATA_MEMORY_MMIO_EN SHALL compile in the I/O window at MMIO_BASE.
REQ-027 With macro, MMIO_BASE+0: io_out, read/write; a write updates io_out at the edge.
REQ-028 With macro, MMIO_BASE+4: reads io_in; writes discarded without fault.
REQ-029 With macro, MMIO_BASE+8: 32-bit cycle counter.
- increments every READY cycle, wraps 0xFFFF_FFFF -> 0.
- a write loads the written value; a simultaneous increment is dropped.
REQ-030 With macro, other words in MMIO_BASE..MMIO_BASE+15 SHALL read 0 and fault on write.
REQ-031 MMIO accesses SHALL be honoured only in READY.
REQ-032 Without macro, MMIO addresses SHALL decode as unmapped; io_out SHALL be tied 0 and no counter logic SHALL exist.

Verification
REQ-033 Reset with DEPTH=256 -> busy=1 for exactly 256 cycles, then 0; every word reads 0.
REQ-034 Write 0xDEADBEEF to 0x10, read 0x10 same cycle -> 0 (old value); next cycle -> 0xDEADBEEF; fault stays 0.
REQ-035 Write to 0x12 (misaligned), then write to 0x400 (DEPTH=256, unmapped) -> neither stored; fault=1 and stays 1 until reset_n=0.
REQ-036 Reset asserted at sweep index 100 after word 0x4 holds 0x55 -> sweep restarts at 0; 256 cycles later 0x4 reads 0.
REQ-037 With DATA_MEMORY_MMIO_EN: write 0x5 to MMIO_BASE+0 -> io_out=0x5 next cycle; io_in=0xA5 -> read MMIO_BASE+4 = 0xA5; write 0xFFFF_FFFE to MMIO_BASE+8 -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on the next three cycles.
REQ-038 Without DATA_MEMORY_MMIO_EN: write to MMIO_BASE+0 -> fault=1, io_out=0, read returns 0.

Source files
------------

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - CPU data bus bundle for data_memory
//
// Purpose: carries one CPU load/store access per cycle between a CPU and data_memory.
// Signals:
//   memory_write_en     write strobe for the current cycle
//   memory_address      byte address
//   memory_write_value  write data
//   memory_read_value   combinational read data for memory_address
// Modports: master (CPU side), slave (memory side).

interface data_memory_if;
  logic        memory_write_en;
  logic [31:0] memory_address;
  logic [31:0] memory_write_value;
  logic [31:0] memory_read_value;

  modport master (
    output memory_write_en,
    output memory_address,
    output memory_write_value,
    input  memory_read_value
  );

  modport slave (
    input  memory_write_en,
    input  memory_address,
    input  memory_write_value,
    output memory_read_value
  );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word RAM with reset-time clear sweep, sticky fault and optional MMIO window
//
// Purpose: DEPTH x 32-bit data RAM with combinational reads and edge-triggered writes.
//   After reset the RAM is cleared one word per cycle (busy=1); CPU accesses are
//   honoured once the sweep is done. Bad writes (misaligned/unmapped) set a sticky fault.
// Optional feature: define DATA_MEMORY_MMIO_EN to add the I/O window at MMIO_BASE
//   (+0 io_out r/w, +4 io_in read-only, +8 free-running cycle counter, +12 reserved).
// Ports:
//   clock       sole clock, rising edge
//   reset_n     synchronous active-low reset
//   bus         data_memory_if.slave CPU access port
//   io_in       external input word (MMIO +4)
//   io_out      registered external output word (MMIO +0); tied 0 without the window
//   busy        high while the clear sweep runs
//   fault       sticky access-error flag, cleared only by reset

module data_memory #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic               clock,
  input  logic               reset_n,
  data_memory_if.slave       bus,
  input  logic [31:0]        io_in,
  output logic [31:0]        io_out,
  output logic               busy,
  output logic               fault
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep_idx;
  logic [31:0]      mem [DEPTH];

  logic             aligned;
  logic             ram_hit;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      mmio_off;
  logic             mmio_hit;
  logic             wr_ok;
  logic             ram_we;
  logic             bad_write;

  // Address decode. RAM takes priority should the window ever overlap it.
  assign aligned  = (bus.memory_address[1:0] == 2'b00);
  assign ram_hit  = aligned && (bus.memory_address < RAM_BYTES);
  assign word_idx = bus.memory_address[IDX_W+1:2];
  // Unsigned subtract folds the window bounds check into a single compare.
  assign mmio_off = bus.memory_address - MMIO_BASE;
  assign mmio_hit = aligned && !ram_hit && (mmio_off < 32'd16);

  // Writes only count in READY; during reset nothing is committed.
  assign wr_ok  = reset_n && (state == ST_READY) && bus.memory_write_en;
  assign ram_we = wr_ok && ram_hit;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:  if (sweep_idx == LAST_IDX) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  assign busy = (state == ST_INIT);

  // Sweep index wraps back to 0 after the last word; it is only consulted in INIT.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sweep_idx <= '0;
    end else if (state == ST_INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
    end
  end

  // RAM array has no reset of its own; the sweep clears it.
  always_ff @(posedge clock) begin
    if (reset_n && (state == ST_INIT)) begin
      mem[sweep_idx] <= '0;
    end else if (ram_we) begin
      mem[word_idx] <= bus.memory_write_value;
    end
  end

`ifdef DATA_MEMORY_MMIO_EN
  logic [1:0]  mmio_sel;
  logic [31:0] cycle_count;
  logic        io_we;
  logic        cnt_we;

  assign mmio_sel  = mmio_off[3:2];
  assign io_we     = wr_ok && mmio_hit && (mmio_sel == 2'd0);
  assign cnt_we    = wr_ok && mmio_hit && (mmio_sel == 2'd2);
  // +4 accepts writes silently; +12 is reserved and faults.
  assign bad_write = wr_ok && !ram_hit && !(mmio_hit && (mmio_sel != 2'd3));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      io_out <= '0;
    end else if (io_we) begin
      io_out <= bus.memory_write_value;
    end
  end

  // A CPU load wins over the increment in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycle_count <= '0;
    end else if (cnt_we) begin
      cycle_count <= bus.memory_write_value;
    end else if (state == ST_READY) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  always_comb begin
    bus.memory_read_value = '0;
    if (state == ST_READY) begin
      if (ram_hit) begin
        bus.memory_read_value = mem[word_idx];
      end else if (mmio_hit) begin
        case (mmio_sel)
          2'd0:    bus.memory_read_value = io_out;
          2'd1:    bus.memory_read_value = io_in;
          2'd2:    bus.memory_read_value = cycle_count;
          default: bus.memory_read_value = '0;
        endcase
      end
    end
  end
`else
  logic unused_mmio;

  assign unused_mmio = ^{io_in, mmio_hit};
  assign io_out      = '0;
  assign bad_write   = wr_ok && !ram_hit;

  always_comb begin
    bus.memory_read_value = '0;
    if ((state == ST_READY) && ram_hit) begin
      bus.memory_read_value = mem[word_idx];
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fault <= 1'b0;
    end else if (bad_write) begin
      fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard testbench for data_memory

module tb_data_memory;

  localparam int          DEPTH     = 256;
  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] io_in = '0;
  logic [31:0] io_out;
  logic        busy;
  logic        fault;

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
    .io_out  (io_out),
    .busy    (busy),
    .fault   (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        busy;
    logic        fault;
    logic [31:0] io;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the memory holds and reports, per the block's rules.
  logic [31:0] m_mem [DEPTH];
  int          m_left = 0;
  bit          m_valid = 1'b0;
  bit          m_fault = 1'b0;
  logic [31:0] m_io = '0;
  logic [31:0] m_cnt = '0;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] ioin);
    if (m_left > 0) return 32'd0;
    if (a[1:0] != 2'b00) return 32'd0;
    if (a < RAM_BYTES) return m_mem[a[IDX_W+1:2]];
`ifdef DATA_MEMORY_MMIO_EN
    if (a == MMIO_BASE) return m_io;
    if (a == MMIO_BASE + 32'd4) return ioin;
    if (a == MMIO_BASE + 32'd8) return m_cnt;
`endif
    return 32'd0;
  endfunction

  task automatic model_step(input bit rn, input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] cnt_next;
    if (!rn) begin
      // After the sweep every word is zero, and nothing is observable before then.
      foreach (m_mem[i]) m_mem[i] = '0;
      m_left  = DEPTH;
      m_fault = 1'b0;
      m_io    = '0;
      m_cnt   = '0;
      m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    if (m_left > 0) begin
      m_left--;
      return;
    end
    cnt_next = m_cnt + 32'd1;
    if (we) begin
      if (a[1:0] != 2'b00) m_fault = 1'b1;
      else if (a < RAM_BYTES) m_mem[a[IDX_W+1:2]] = d;
`ifdef DATA_MEMORY_MMIO_EN
      else if (a == MMIO_BASE) m_io = d;
      else if (a == MMIO_BASE + 32'd4) ;
      else if (a == MMIO_BASE + 32'd8) cnt_next = d;
`endif
      else m_fault = 1'b1;
    end
    m_cnt = cnt_next;
  endtask

  // One CPU cycle: drive, record what the DUT must show before the next edge, advance the model.
  task automatic cycle(input bit rn, input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clock);
    #1;
    reset_n                = rn;
    bus.memory_write_en    = we;
    bus.memory_address     = a;
    bus.memory_write_value = d;
    io_in                  = $urandom;
    if (m_valid) begin
      e.addr  = a;
      e.rd    = model_read(a, io_in);
      e.busy  = (m_left > 0);
      e.fault = m_fault;
      e.io    = m_io;
      sb.push_back(e);
    end
    model_step(rn, we, a, d);
  endtask

  task automatic check(input string name, input logic [31:0] addr, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s addr=%h actual=%h expected=%h t=%0t", name, addr, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("read_value", e.addr, bus.memory_read_value, e.rd);
      check("busy",       e.addr, {31'd0, busy},         {31'd0, e.busy});
      check("fault",      e.addr, {31'd0, fault},        {31'd0, e.fault});
      check("io_out",     e.addr, io_out,                e.io);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      5:             a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      6:             a = RAM_BYTES + (32'($urandom_range(0, 63)) << 2);
      7, 8:          a = MMIO_BASE + (32'($urandom_range(0, 3)) << 2);
      default:       a = $urandom;
    endcase
    return a;
  endfunction

  task automatic reset_and_sweep();
    cycle(1'b0, 1'b0, '0, '0);
    // Random traffic during the sweep: writes must be ignored and never fault.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
  endtask

  initial begin
    bus.memory_write_en    = 1'b0;
    bus.memory_address     = '0;
    bus.memory_write_value = '0;

    cycle(1'b0, 1'b0, '0, '0);
    reset_and_sweep();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'(i) << 2, '0);

    // Same-cycle read returns the old value; next cycle the new one.
    cycle(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 32'h10, '0);
    cycle(1'b1, 1'b0, 32'h10, '0);

    // Misaligned and unmapped writes are dropped and latch fault.
    cycle(1'b1, 1'b1, 32'h12, 32'h1234_5678);
    cycle(1'b1, 1'b1, 32'h400, 32'h8765_4321);
    cycle(1'b1, 1'b0, 32'h10, '0);
    cycle(1'b1, 1'b0, 32'h400, '0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h10, '0);

    // MMIO window (or unmapped region, in the default build).
    reset_and_sweep();
    cycle(1'b1, 1'b1, MMIO_BASE, 32'h5);
    cycle(1'b1, 1'b0, MMIO_BASE, '0);
    cycle(1'b1, 1'b0, MMIO_BASE + 32'd4, '0);
    cycle(1'b1, 1'b1, MMIO_BASE + 32'd8, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, MMIO_BASE + 32'd8, '0);
    cycle(1'b1, 1'b1, MMIO_BASE + 32'd12, 32'h1);
    cycle(1'b1, 1'b0, MMIO_BASE + 32'd12, '0);

    // Reset mid-sweep restarts the clear.
    reset_and_sweep();
    cycle(1'b1, 1'b1, 32'h4, 32'h55);
    cycle(1'b1, 1'b0, 32'h4, '0);
    cycle(1'b0, 1'b0, 32'h4, '0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 32'h4, '0);
    cycle(1'b0, 1'b0, 32'h4, '0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b1, 1'b0, 32'h4, '0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) cycle(1'b0, 1'b0, '0, '0);
      else cycle(1'b1, ($urandom_range(0, 3) == 0), rand_addr(), $urandom);
    end

    // Let the monitor drain; a leftover expectation counts as a failure.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clock);
    check("scoreboard_drained", '0, 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
